// File: rtl/count_read_latch.sv
// Read-back latch for one counter: holds a count snapshot and an optional status byte for CPU reads.
// Status latch is built only when READBACK_STATUS_EN is defined.
module count_read_latch (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] current_count,
    input  logic [1:0]  RW,
    input  logic        mode_write,
    input  logic        latch_cmd,
    input  logic        status_cmd,
    input  logic [7:0]  status_in,
    input  logic        rd_strobe,
    output logic [7:0]  data_out,
    output logic        count_latched,
    output logic        status_latched,
    output logic        msb_next
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_HELD_BOTH = 2'd1,
        ST_HELD_MSB  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_snapshot;
    logic [CNT_W-1:0]    w_snapshot_nxt;
    logic                r_msb_next;
    logic                w_msb_next_nxt;
    logic                w_status_pending;
    logic                w_count_rd;
    logic                w_count_cleared;
    logic                w_sel_hi;
    logic [CNT_W-1:0]    w_count_src;
    logic [BYTE_W-1:0]   w_count_byte;
    logic [BYTE_W-1:0]   w_status_byte;

    assign count_latched = (r_state != ST_FREE);
    assign msb_next      = r_msb_next;

`ifdef READBACK_STATUS_EN
    logic               r_status_latched;
    logic               w_status_latched_nxt;
    logic [BYTE_W-1:0]  r_status;
    logic [BYTE_W-1:0]  w_status_nxt;

    // A read that drains the pending status lets a same-edge status_cmd reload it.
    always_comb begin
        w_status_latched_nxt = r_status_latched;
        w_status_nxt         = r_status;
        if (mode_write) begin
            w_status_latched_nxt = 1'b0;
        end else begin
            if (rd_strobe && r_status_latched) begin
                w_status_latched_nxt = 1'b0;
            end
            if (status_cmd && (!r_status_latched || rd_strobe)) begin
                w_status_nxt         = status_in;
                w_status_latched_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_status_latched <= 1'b0;
            r_status         <= '0;
        end else begin
            r_status_latched <= w_status_latched_nxt;
            r_status         <= w_status_nxt;
        end
    end

    assign w_status_pending = r_status_latched;
    assign w_status_byte    = r_status;
`else
    logic w_unused_status;

    assign w_unused_status  = ^{status_cmd, status_in};
    assign w_status_pending = 1'b0;
    assign w_status_byte    = '0;
`endif

    assign status_latched = w_status_pending;

    // Byte presented to the CPU; pending status shadows the count.
    always_comb begin
        w_count_src  = count_latched ? r_snapshot : current_count;
        w_sel_hi     = (RW == 2'b10) || ((RW == 2'b11) && r_msb_next);
        w_count_byte = w_sel_hi ? w_count_src[CNT_W-1:BYTE_W] : w_count_src[BYTE_W-1:0];
        data_out     = w_status_pending ? w_status_byte : w_count_byte;
    end

    // Count-side next state: read consumption first, then latch_cmd against pre-edge flags.
    always_comb begin
        w_state_nxt     = r_state;
        w_snapshot_nxt  = r_snapshot;
        w_msb_next_nxt  = r_msb_next;
        w_count_rd      = rd_strobe && !w_status_pending;
        w_count_cleared = 1'b0;
        if (mode_write) begin
            w_state_nxt    = ST_FREE;
            w_msb_next_nxt = 1'b0;
        end else begin
            if (w_count_rd) begin
                if (RW == 2'b11) begin
                    w_msb_next_nxt = !r_msb_next;
                    case (r_state)
                        ST_HELD_BOTH: w_state_nxt = ST_HELD_MSB;
                        ST_HELD_MSB:  w_state_nxt = ST_FREE;
                        default:      w_state_nxt = ST_FREE;
                    endcase
                end else begin
                    w_state_nxt = ST_FREE;
                end
                w_count_cleared = (r_state != ST_FREE) && (w_state_nxt == ST_FREE);
            end
            if (latch_cmd && ((r_state == ST_FREE) || w_count_cleared)) begin
                w_snapshot_nxt = current_count;
                w_state_nxt    = ST_HELD_BOTH;
                if (RW == 2'b11) begin
                    w_msb_next_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_FREE;
            r_snapshot <= '0;
            r_msb_next <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_snapshot <= w_snapshot_nxt;
            r_msb_next <= w_msb_next_nxt;
        end
    end

endmodule

// File: doc/count_read_latch.md
COUNT_READ_LATCH -- requirements
Module: count_read_latch

Interface
REQ-001 CLK  input  1  counter-side clock; all state changes on rising edge.
REQ-002 RST_N  input  1  reset; asynchronous, active-low.
REQ-003 current_count  input  16  live count from the counting element.
REQ-004 RW  input  2  programmed access mode: 01 LSB only, 10 MSB only, 11 LSB then MSB; 00 never stored as a mode.
REQ-005 mode_write  input  1  one-cycle pulse: control word written to this counter.
REQ-006 latch_cmd  input  1  one-cycle pulse: counter latch command.
REQ-007 status_cmd  input  1  one-cycle pulse: status latch command.
REQ-008 status_in  input  8  status byte {OUT, null_count, RW[1:0], mode[2:0], BCD}.
REQ-009 rd_strobe  input  1  one-cycle pulse: CPU read of this counter completes this cycle.
REQ-010 data_out  output  8  byte the CPU reads; combinational from state and current_count.
REQ-011 count_latched  output  1  high while a latched count is pending.
REQ-012 status_latched  output  1  high while a latched status is pending.
REQ-013 msb_next  output  1  RW=11 byte pointer; high = next count byte is MSB.

Function
REQ-014 Count latch states: FREE (data_out follows current_count), HELD_BOTH (16-bit snapshot held), HELD_MSB (LSB read, MSB of snapshot pending).
REQ-015 latch_cmd in FREE: snapshot <= current_count; RW=01/10 -> HELD_BOTH; RW=11 -> HELD_BOTH with msb_next=0.
REQ-016 latch_cmd while count_latched=1: ignored; snapshot unchanged.
REQ-017 Count byte select: RW=01 -> [7:0]; RW=10 -> [15:8]; RW=11 -> [7:0] if msb_next=0, else [15:8]; source = snapshot if latched, else current_count.
REQ-018 rd_strobe consuming a count byte: RW=01/10 -> FREE; RW=11 -> toggle msb_next; HELD_BOTH -> HELD_MSB after LSB; HELD_MSB -> FREE after MSB.
REQ-019 Unlatched RW=11 read: each byte sampled live at its own read; pointer toggles identically.
REQ-020 status_cmd with status_latched=0: status register <= status_in, status_latched=1; ignored if already latched.
REQ-021 Status priority: status_latched=1 -> data_out = status register; rd_strobe clears status_latched only; count state and msb_next unchanged.
REQ-022 Same-edge rd_strobe with latch_cmd/status_cmd: read consumes pre-edge data_out; commands evaluated on pre-edge flags, except a command whose flag this read clears is accepted.
REQ-023 mode_write: highest priority; clears both latches, msb_next=0, state FREE; same-cycle commands and reads ignored.
REQ-024 rd_strobe with nothing latched in RW=01/10: no state change.
REQ-025 No per-cycle latency on data_out; state updates visible the cycle after the edge.

Reset
REQ-026 RST_N low: immediately state FREE, snapshot=16'h0000, status register=8'h00, count_latched=0, status_latched=0, msb_next=0.
REQ-027 Reset mid-sequence (HELD_MSB or status pending): all pending data discarded; first read after release returns live LSB (RW=01/11).

Configuration
REQ-028 Macro READBACK_STATUS_EN defined: status latch per REQ-020/021 present.
REQ-029 READBACK_STATUS_EN undefined: no status register; status_cmd and status_in ignored; status_latched tied 0; data_out always the count byte.

Verification
REQ-030 RW=11, current_count=16'h1234, latch_cmd; count moves to 16'h1200; two reads -> 8'h34 then 8'h12; count_latched falls after second.
REQ-031 RW=01, latch at 16'h00A5, second latch_cmd at 16'h0050 before read -> read returns 8'hA5; then FREE.
REQ-032 RW=11, status_in=8'hB6, status_cmd then latch_cmd at 16'hBEEF -> reads 8'hB6, 8'hEF, 8'hBE.
REQ-033 RW=11, latch 16'hCAFE, one read (8'hFE), mode_write -> flags 0, msb_next 0; next read returns live LSB.
REQ-034 RW=11 HELD_MSB, RST_N pulsed low mid-cycle -> outputs reset immediately without clock edge.
REQ-035 READBACK_STATUS_EN undefined: status_cmd with status_in=8'hFF -> status_latched stays 0; read returns count byte.
